// File: rtl/clct_busy_window_pkg.sv
// Shared pattern-finder parameters and busy-window FSM state encoding.
package clct_busy_window_pkg;

    localparam int unsigned MXKEYBX = 8;    // extended half-strip key width
    localparam int unsigned NGRP    = 5;    // key groups feeding the sorter
    localparam int unsigned GRPW    = 32;   // half-strips per group
    localparam int unsigned NKEY    = 160;  // NGRP*GRPW valid keys
    localparam int unsigned MXSPRB  = 5;    // cfg_spread width
    localparam int unsigned MXDEADB = 4;    // cfg_dead_bx / hold counter width

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/clct_window_grp_mask.sv
// Combinational key window (clamped to the valid key range) and per-group overlap mask.
module clct_window_grp_mask
    import clct_busy_window_pkg::*;
(
    input  logic [MXKEYBX-1:0] key,
    input  logic [MXSPRB-1:0]  spread,
    output logic [MXKEYBX-1:0] lo_c,
    output logic [MXKEYBX-1:0] hi_c,
    output logic [NGRP-1:0]    mask_c
);

    localparam int unsigned W = MXKEYBX + 1;

    logic [W-1:0] key_x;
    logic [W-1:0] spr_x;
    logic [W-1:0] sum_x;
    logic [W-1:0] lo_x;
    logic [W-1:0] hi_x;

    assign key_x = W'(key);
    assign spr_x = W'(spread);
    assign sum_x = key_x + spr_x;

    // Clamp window edges to [0, NKEY-1]; one extra bit keeps the sum from wrapping.
    always_comb begin
        lo_x = '0;
        hi_x = sum_x;
        if (key_x >= spr_x)
            lo_x = key_x - spr_x;
        if (sum_x > W'(NKEY - 1))
            hi_x = W'(NKEY - 1);
    end

    assign lo_c = MXKEYBX'(lo_x);
    assign hi_c = MXKEYBX'(hi_x);

    // A group is busy when its half-strip span intersects the window.
    for (genvar g = 0; g < int'(NGRP); g++) begin : g_grp
        localparam logic [W-1:0] GRP_LO = W'(g * GRPW);
        localparam logic [W-1:0] GRP_HI = W'(g * GRPW + GRPW - 1);
        assign mask_c[g] = (lo_x <= GRP_HI) && (hi_x >= GRP_LO);
    end

endmodule

// File: rtl/clct_busy_window.sv
// Busy-group generator for the 2nd-CLCT search: holds a key window around the
// accepted 1st CLCT for a programmable number of bx.
module clct_busy_window
    import clct_busy_window_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               clct0_vld,
    input  logic [MXKEYBX-1:0] clct0_key,
    input  logic [MXSPRB-1:0]  cfg_spread,
    input  logic [MXDEADB-1:0] cfg_dead_bx,
    output logic [NGRP-1:0]    bsy,
    output logic [MXKEYBX-1:0] bsy_key_lo,
    output logic [MXKEYBX-1:0] bsy_key_hi,
    output logic               busy_active,
    output logic [MXDEADB-1:0] hold_cnt,
    output logic               retrig,
    output logic               key_err
);

    state_t               state;
    logic                 key_ok;
    logic                 accept;
    logic                 bad_key;
    logic [MXDEADB-1:0]   dead_m1;
    logic [MXKEYBX-1:0]   win_lo_c;
    logic [MXKEYBX-1:0]   win_hi_c;
    logic [NGRP-1:0]      win_mask_c;

    assign key_ok  = (clct0_key < MXKEYBX'(NKEY));
    assign accept  = clct0_vld & enable & key_ok;
    assign bad_key = clct0_vld & enable & ~key_ok;
    // A dead time of 0 behaves like 1 bx.
    assign dead_m1 = (cfg_dead_bx == '0) ? '0 : cfg_dead_bx - MXDEADB'(1);

    clct_window_grp_mask u_mask (
        .key    (clct0_key),
        .spread (cfg_spread),
        .lo_c   (win_lo_c),
        .hi_c   (win_hi_c),
        .mask_c (win_mask_c)
    );

    // State, window latch, hold countdown and single-cycle status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bsy         <= '0;
            bsy_key_lo  <= '0;
            bsy_key_hi  <= '0;
            busy_active <= 1'b0;
            hold_cnt    <= '0;
            retrig      <= 1'b0;
            key_err     <= 1'b0;
        end else begin
            retrig  <= 1'b0;
            key_err <= bad_key;
            if (!enable) begin
                state       <= IDLE;
                bsy         <= '0;
                bsy_key_lo  <= '0;
                bsy_key_hi  <= '0;
                busy_active <= 1'b0;
                hold_cnt    <= '0;
            end else if (accept) begin
                // Fresh load or retrigger: the new window replaces the old one.
                state       <= HOLD;
                bsy         <= win_mask_c;
                bsy_key_lo  <= win_lo_c;
                bsy_key_hi  <= win_hi_c;
                busy_active <= 1'b1;
                hold_cnt    <= dead_m1;
                retrig      <= (state == HOLD);
            end else begin
                case (state)
                    HOLD: begin
                        if (hold_cnt != '0) begin
                            hold_cnt <= hold_cnt - MXDEADB'(1);
                        end else begin
                            state       <= IDLE;
                            bsy         <= '0;
                            bsy_key_lo  <= '0;
                            bsy_key_hi  <= '0;
                            busy_active <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clct_busy_window.sv
// Directed scoreboard bench for clct_busy_window.
module tb_clct_busy_window;
    import clct_busy_window_pkg::*;

    logic               clock;
    logic               reset;
    logic               enable;
    logic               clct0_vld;
    logic [MXKEYBX-1:0] clct0_key;
    logic [MXSPRB-1:0]  cfg_spread;
    logic [MXDEADB-1:0] cfg_dead_bx;
    logic [NGRP-1:0]    bsy;
    logic [MXKEYBX-1:0] bsy_key_lo;
    logic [MXKEYBX-1:0] bsy_key_hi;
    logic               busy_active;
    logic [MXDEADB-1:0] hold_cnt;
    logic               retrig;
    logic               key_err;

    clct_busy_window dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .clct0_vld   (clct0_vld),
        .clct0_key   (clct0_key),
        .cfg_spread  (cfg_spread),
        .cfg_dead_bx (cfg_dead_bx),
        .bsy         (bsy),
        .bsy_key_lo  (bsy_key_lo),
        .bsy_key_hi  (bsy_key_hi),
        .busy_active (busy_active),
        .hold_cnt    (hold_cnt),
        .retrig      (retrig),
        .key_err     (key_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef logic [27:0] obs_t;   // {bsy, lo, hi, active, cnt, retrig, key_err}

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic obs_t pack(input logic [4:0] b, input int lo, input int hi,
                                  input logic a, input int c, input logic r, input logic k);
        return {b, 8'(lo), 8'(hi), a, 4'(c), r, k};
    endfunction

    // Monitor: outputs are registered, so compare on every falling edge while expectations are pending.
    always @(negedge clock) begin
        obs_t  e;
        obs_t  a;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {bsy, bsy_key_lo, bsy_key_hi, busy_active, hold_cnt, retrig, key_err};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got bsy=%b lo=%0d hi=%0d act=%b cnt=%0d rt=%b ke=%b, want bsy=%b lo=%0d hi=%0d act=%b cnt=%0d rt=%b ke=%b",
                         n, a[27:23], a[22:15], a[14:7], a[6], a[5:2], a[1], a[0],
                         e[27:23], e[22:15], e[14:7], e[6], e[5:2], e[1], e[0]);
            end
        end
    end

    // Drive one cycle of inputs at the falling edge; queue the outputs expected after the next rising edge.
    task automatic step(input string nm, input logic en, input logic vld, input int key,
                        input int spr, input int dead, input logic [4:0] eb, input int elo,
                        input int ehi, input logic ea, input int ec, input logic er,
                        input logic ek);
        enable      = en;
        clct0_vld   = vld;
        clct0_key   = 8'(key);
        cfg_spread  = 5'(spr);
        cfg_dead_bx = 4'(dead);
        @(posedge clock);
        exp_q.push_back(pack(eb, elo, ehi, ea, ec, er, ek));
        name_q.push_back(nm);
        @(negedge clock);
    endtask

    task automatic idle(input string nm, input logic [4:0] eb, input int elo, input int ehi,
                        input logic ea, input int ec);
        step(nm, 1'b1, 1'b0, 0, 0, 0, eb, elo, ehi, ea, ec, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; clct0_vld = 1'b0;
        clct0_key = '0; cfg_spread = '0; cfg_dead_bx = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        idle("reset_state", 5'b00000, 0, 0, 1'b0, 0);

        // Basic window; spread/dead changes during HOLD must be ignored.
        step("basic_n1", 1, 1, 40, 10, 4, 5'b00011, 30, 50, 1, 3, 0, 0);
        step("basic_n2", 1, 0, 40, 31, 9, 5'b00011, 30, 50, 1, 2, 0, 0);
        step("basic_n3", 1, 0, 0, 31, 9, 5'b00011, 30, 50, 1, 1, 0, 0);
        idle("basic_n4", 5'b00011, 30, 50, 1, 0);
        idle("basic_n5", 5'b00000, 0, 0, 0, 0);

        // Clamps at both ends of the key range.
        step("lo_clamp", 1, 1, 5, 10, 1, 5'b00001, 0, 15, 1, 0, 0, 0);
        idle("lo_clamp_end", 5'b00000, 0, 0, 0, 0);
        step("hi_clamp", 1, 1, 155, 10, 1, 5'b10000, 145, 159, 1, 0, 0, 0);
        idle("hi_clamp_end", 5'b00000, 0, 0, 0, 0);

        // Retrigger on the 3rd HOLD cycle.
        step("rt_load", 1, 1, 40, 10, 4, 5'b00011, 30, 50, 1, 3, 0, 0);
        idle("rt_h2", 5'b00011, 30, 50, 1, 2);
        idle("rt_h3", 5'b00011, 30, 50, 1, 1);
        step("rt_reload", 1, 1, 100, 10, 4, 5'b01100, 90, 110, 1, 3, 1, 0);
        idle("rt_c2", 5'b01100, 90, 110, 1, 2);
        idle("rt_c1", 5'b01100, 90, 110, 1, 1);
        idle("rt_c0", 5'b01100, 90, 110, 1, 0);
        idle("rt_end", 5'b00000, 0, 0, 0, 0);

        // Retrigger on the last HOLD cycle.
        step("rl_load", 1, 1, 40, 10, 2, 5'b00011, 30, 50, 1, 1, 0, 0);
        idle("rl_last", 5'b00011, 30, 50, 1, 0);
        step("rl_reload", 1, 1, 100, 10, 2, 5'b01100, 90, 110, 1, 1, 1, 0);
        idle("rl_c0", 5'b01100, 90, 110, 1, 0);
        idle("rl_end", 5'b00000, 0, 0, 0, 0);

        // Invalid key in IDLE and during HOLD.
        step("bad_idle", 1, 1, 200, 10, 4, 5'b00000, 0, 0, 0, 0, 0, 1);
        idle("bad_idle_clr", 5'b00000, 0, 0, 0, 0);
        step("bad_h_load", 1, 1, 40, 10, 3, 5'b00011, 30, 50, 1, 2, 0, 0);
        step("bad_hold", 1, 1, 200, 0, 9, 5'b00011, 30, 50, 1, 1, 0, 1);
        idle("bad_h_c0", 5'b00011, 30, 50, 1, 0);
        idle("bad_h_end", 5'b00000, 0, 0, 0, 0);

        // Dead time of zero acts as one bx.
        step("dead0", 1, 1, 64, 0, 0, 5'b00100, 64, 64, 1, 0, 0, 0);
        idle("dead0_end", 5'b00000, 0, 0, 0, 0);

        // Enable drop during HOLD, then a strobe while disabled.
        step("en_load", 1, 1, 40, 10, 4, 5'b00011, 30, 50, 1, 3, 0, 0);
        step("en_drop", 0, 0, 40, 10, 4, 5'b00000, 0, 0, 0, 0, 0, 0);
        step("en_off_vld", 0, 1, 40, 10, 4, 5'b00000, 0, 0, 0, 0, 0, 0);
        idle("en_back", 5'b00000, 0, 0, 0, 0);

        // Asynchronous reset between clock edges mid-HOLD.
        step("ar_load", 1, 1, 40, 10, 4, 5'b00011, 30, 50, 1, 3, 0, 0);
        idle("ar_h2", 5'b00011, 30, 50, 1, 2);
        @(posedge clock);
        #2 reset = 1'b1;
        exp_q.push_back(pack(5'b00000, 0, 0, 1'b0, 0, 1'b0, 1'b0));
        name_q.push_back("async_rst");
        @(negedge clock);
        reset = 1'b0;
        step("ar_k10", 1, 1, 10, 10, 4, 5'b00001, 0, 20, 1, 3, 0, 0);
        idle("ar_k10_c2", 5'b00001, 0, 20, 1, 2);
        idle("ar_k10_c1", 5'b00001, 0, 20, 1, 1);
        idle("ar_k10_c0", 5'b00001, 0, 20, 1, 0);
        idle("ar_k10_end", 5'b00000, 0, 0, 0, 0);

        repeat (2) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
